// File: rtl/ring_bridge_router_pkg.sv
// Shared flit field constants, types and helpers for the ring bridge router.
package ring_bridge_router_pkg;

   localparam int unsigned FLIT_W_DEF    = 64;
   localparam int unsigned VALID_BIT_DEF = FLIT_W_DEF - 1;
   localparam int unsigned DEST_LSB_DEF  = 0;
   localparam int unsigned DEST_W_DEF    = 4;
   localparam int unsigned DEPTH_DEF     = 8;
   localparam int unsigned CNT_W_DEF     = 16;

   // Widest flit the helpers accept; narrower flits are zero-extended.
   localparam int unsigned MAX_FLIT_W    = 256;

   typedef logic [FLIT_W_DEF-1:0] flit_t;
   typedef logic [MAX_FLIT_W-1:0] flit_max_t;

   // Extract the destination field (up to 32 bits) at position lsb, width w.
   function automatic logic [31:0] dest_of(input flit_max_t flit,
                                           input int unsigned lsb,
                                           input int unsigned w);
      flit_max_t   sh;
      logic [31:0] mask;
      sh   = flit >> lsb;
      mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return sh[31:0] & mask;
   endfunction

   // Inclusive range test used to classify productive destinations.
   function automatic logic in_range(input logic [31:0] dest,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
      return (dest >= lo) && (dest <= hi);
   endfunction

endpackage

// File: rtl/ring_bridge_router_if.sv
// Ring, injection and bridge-buffer signals of the ring bridge router.
interface ring_bridge_router_if
   import ring_bridge_router_pkg::*;
#(
   parameter int unsigned FLIT_W = FLIT_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [FLIT_W-1:0] ring_in;
   logic [FLIT_W-1:0] inj;
   logic [FLIT_W-1:0] ring_out;
   logic              accept;
   logic [FLIT_W-1:0] buf_out;
   logic              buf_valid;
   logic              buf_pop;
   logic [CW-1:0]     buf_count;
   logic              buf_full;
   logic [CNT_W-1:0]  defl_count;

   // Router side.
   modport slave (
      input  ring_in, inj, buf_pop,
      output ring_out, accept, buf_out, buf_valid, buf_count, buf_full, defl_count
   );

   // Environment side (upstream ring node, injector, bridge consumer).
   modport master (
      output ring_in, inj, buf_pop,
      input  ring_out, accept, buf_out, buf_valid, buf_count, buf_full, defl_count
   );

endinterface

// File: rtl/ring_bridge_router_bridge_fifo.sv
// Circular bridge FIFO; a push while full succeeds if a real pop happens
// in the same cycle.
module bridge_fifo #(
   parameter int unsigned W     = 64,
   parameter int unsigned DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 in,
   output logic [W-1:0]                 out,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  rf [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          pop_eff;
   logic          push_eff;

   // Effective handshakes and status flags.
   always_comb begin
      empty    = (count == '0);
      full     = (count == CW'(DEPTH));
      pop_eff  = pop && !empty;
      push_eff = push && (!full || pop_eff);
      out      = empty ? '0 : rf[head];
   end

   // Storage array; contents need no reset since out is masked when empty.
   always_ff @(posedge clk) begin
      if (push_eff && !rst) begin
         rf[tail] <= in;
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_eff) tail <= tail + 1'b1;
         if (pop_eff)  head <= head + 1'b1;
         count <= count + CW'(push_eff) - CW'(pop_eff);
      end
   end

endmodule

// File: rtl/ring_bridge_router.sv
// Two-stage ring router: ejects productive flits into the bridge FIFO,
// passes others through, injects into freed slots, counts deflections.
module ring_bridge_router
   import ring_bridge_router_pkg::*;
#(
   parameter int unsigned FLIT_W   = FLIT_W_DEF,
   parameter int unsigned DEST_LSB = DEST_LSB_DEF,
   parameter int unsigned DEST_W   = DEST_W_DEF,
   parameter int unsigned DEST_LO  = 4,
   parameter int unsigned DEST_HI  = 11,
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   ring_bridge_router_if.slave  bus
);
   localparam int unsigned    VALID_BIT = FLIT_W - 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [FLIT_W-1:0] ring_r;
   logic [FLIT_W-1:0] slot;
   logic [FLIT_W-1:0] next_flit;
   logic              productive;
   logic              pop_eff;
   logic              push;
   logic              deflect;
   logic              fifo_empty;
   flit_max_t         ring_ext;

   bridge_fifo #(
      .W     (FLIT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (productive),
      .pop   (bus.buf_pop),
      .in    (ring_r),
      .out   (bus.buf_out),
      .count (bus.buf_count),
      .full  (bus.buf_full),
      .empty (fifo_empty)
   );

   assign bus.buf_valid = !fifo_empty;

   // Stage-1 classification, slot reuse and injection arbitration.
   // push mirrors the FIFO's own acceptance rule so the slot is freed only
   // when the flit really lands in the buffer.
   always_comb begin
      ring_ext                = '0;
      ring_ext[FLIT_W-1:0]    = ring_r;
      productive = ring_r[VALID_BIT] &&
                   in_range(dest_of(ring_ext, DEST_LSB, DEST_W), DEST_LO, DEST_HI);
      pop_eff    = bus.buf_pop && !fifo_empty;
      push       = productive && (!bus.buf_full || pop_eff);
      deflect    = productive && !push;
      slot       = push ? '0 : ring_r;
      bus.accept = bus.inj[VALID_BIT] && !slot[VALID_BIT] && !rst;
      next_flit  = bus.accept ? bus.inj : slot;
   end

   // Ring pipeline registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ring_r       <= '0;
         bus.ring_out <= '0;
      end else begin
         ring_r       <= bus.ring_in;
         bus.ring_out <= next_flit;
      end
   end

   // Saturating deflection counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.defl_count <= '0;
      end else if (deflect && (bus.defl_count != CNT_MAX)) begin
         bus.defl_count <= bus.defl_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_ring_bridge_router.sv
// Self-checking bench for ring_bridge_router against a queue-based model.
module tb_ring_bridge_router;

   localparam int unsigned FW    = 64;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CNT_W = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ring_bridge_router_if #(.FLIT_W(FW), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   ring_bridge_router #(
      .FLIT_W   (FW),
      .DEST_LSB (0),
      .DEST_W   (4),
      .DEST_LO  (4),
      .DEST_HI  (11),
      .DEPTH    (DEPTH),
      .CNT_W    (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   // Model state: stage-1 flit, output register, buffered flits, deflections.
   logic [FW-1:0] m_r;
   logic [FW-1:0] m_out;
   logic [FW-1:0] q[$];
   int unsigned   m_defl;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [FW-1:0] mk(input logic v, input logic [3:0] d, input logic [31:0] pl);
      logic [FW-1:0] f;
      f        = '0;
      f[FW-1]  = v;
      f[35:4]  = pl;
      f[3:0]   = d;
      return f;
   endfunction

   // One clock cycle: check registered outputs, drive inputs, check accept,
   // then advance the model to what the next edge must produce.
   task automatic cyc(input logic [FW-1:0] rin, input logic [FW-1:0] ij,
                      input logic pop, input logic r);
      logic          prod, popd, pushd, acc;
      logic [FW-1:0] slot, nxt, head;
      int unsigned   d;
      @(negedge clk);
      head = (q.size() != 0) ? q[0] : '0;
      check_eq("ring_out",   bus.ring_out,   m_out);
      check_eq("buf_valid",  64'(bus.buf_valid), 64'(q.size() != 0));
      check_eq("buf_out",    bus.buf_out,    head);
      check_eq("buf_count",  64'(bus.buf_count), 64'(q.size()));
      check_eq("buf_full",   64'(bus.buf_full),  64'(q.size() == DEPTH));
      check_eq("defl_count", 64'(bus.defl_count), 64'(m_defl));
      bus.ring_in = rin;
      bus.inj     = ij;
      bus.buf_pop = pop;
      rst         = r;
      #1;
      if (r) begin
         check_eq("accept_rst", 64'(bus.accept), 64'(0));
         m_r    = '0;
         m_out  = '0;
         q      = {};
         m_defl = 0;
      end else begin
         d     = int'(m_r[3:0]);
         prod  = m_r[FW-1] && d >= 4 && d <= 11;
         popd  = pop && q.size() > 0;
         pushd = prod && (q.size() < DEPTH || popd);
         slot  = pushd ? '0 : m_r;
         acc   = ij[FW-1] && !slot[FW-1];
         nxt   = acc ? ij : slot;
         check_eq("accept", 64'(bus.accept), 64'(acc));
         if (prod && !pushd && m_defl < 65535) m_defl++;
         if (popd) void'(q.pop_front());
         if (pushd) q.push_back(m_r);
         m_out = nxt;
         m_r   = rin;
      end
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cyc('0, '0, 1'b0, 1'b0);
   endtask

   task automatic drain(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cyc('0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      rst         = 1'b1;
      bus.ring_in = '0;
      bus.inj     = '0;
      bus.buf_pop = 1'b0;
      repeat (2) @(posedge clk);
      m_r = '0; m_out = '0; q = {}; m_defl = 0;

      // Pass-through of a non-productive flit.
      cyc(mk(1'b1, 4'd2, 32'hA5A5_0001), '0, 1'b0, 1'b0);
      idle(3);

      // Ejection into the bridge buffer, then drain.
      cyc(mk(1'b1, 4'd7, 32'hB0B0_0002), '0, 1'b0, 1'b0);
      idle(3);
      drain(2);

      // Slot reuse: injection takes the slot freed by the ejected flit.
      cyc(mk(1'b1, 4'd7, 32'hC0C0_0003), '0, 1'b0, 1'b0);
      cyc('0, mk(1'b1, 4'd1, 32'hD0D0_0004), 1'b0, 1'b0);
      idle(2);
      drain(2);

      // Fill, deflect the ninth, then push-with-pop while full.
      for (int unsigned i = 0; i < 8; i++)
         cyc(mk(1'b1, 4'(4 + i), 32'h1000_0000 + i), '0, 1'b0, 1'b0);
      cyc(mk(1'b1, 4'd9, 32'hE0E0_0005), '0, 1'b0, 1'b0);
      cyc('0, mk(1'b1, 4'd3, 32'hF0F0_0006), 1'b0, 1'b0);
      idle(2);
      cyc(mk(1'b1, 4'd9, 32'h6060_0007), '0, 1'b0, 1'b0);
      cyc('0, mk(1'b1, 4'd2, 32'h7070_0008), 1'b1, 1'b0);
      idle(2);
      drain(10);

      // Ordering and pointer wrap with pop every other cycle.
      for (int unsigned i = 0; i < 20; i++)
         cyc(mk(1'b1, 4'(4 + (i % 8)), 32'h2000_0000 + i), '0, 1'(i % 2), 1'b0);
      drain(14);

      // Reset mid-operation with five buffered flits and injection pending.
      for (int unsigned i = 0; i < 5; i++)
         cyc(mk(1'b1, 4'(5 + i), 32'h3000_0000 + i), '0, 1'b0, 1'b0);
      idle(2);
      cyc(mk(1'b1, 4'd6, 32'h4444_0009), mk(1'b1, 4'd1, 32'h5555_000A), 1'b0, 1'b1);
      cyc('0, '0, 1'b1, 1'b0);
      idle(2);

      // Randomized traffic.
      for (int unsigned i = 0; i < 600; i++) begin
         logic [FW-1:0] rin, ij;
         rin = mk(1'($urandom_range(0, 9) < 6), 4'($urandom), $urandom);
         ij  = mk(1'($urandom_range(0, 1)), 4'($urandom), $urandom);
         cyc(rin, ij, 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 149) == 0));
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
